// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: state, port-id and counter encodings shared by the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the shared memory bus.
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner_d;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner_d
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner_d
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the port that did not win last time goes.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_d
);
  assign gnt_valid = req_i | req_d;
  assign gnt_d     = req_d & (~req_i | (last_grant == PORT_I));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (I) and data (D) requesters
// with an IDLE -> ACCESS -> DONE sequencer holding the bus for LAT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input logic              CLK,
  input logic              RST,
  mem_port_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             owner_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             i_ack_q;
  logic             d_ack_q;
  logic [DW-1:0]    i_rdata_q;
  logic [DW-1:0]    d_rdata_q;
  logic             gnt_valid;
  logic             gnt_d;
  rr_pick2 u_pick (
    .req_i      (bus.i_req),
    .req_d      (bus.d_req),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_d      (gnt_d)
  );
  // Request fields are copied at the grant edge so requester changes mid-access are ignored.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= PORT_D;
      owner_q   <= PORT_I;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE:
          if (gnt_valid) begin
            state_q  <= ST_ACCESS;
            cnt_q    <= '0;
            owner_q  <= gnt_d;
            last_q   <= gnt_d;
            mem_en_q <= 1'b1;
            mem_we_q <= gnt_d & bus.d_we;
            addr_q   <= gnt_d ? bus.d_addr : bus.i_addr;
            wdata_q  <= gnt_d ? bus.d_wdata : '0;
          end
        ST_ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= ST_DONE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            i_ack_q  <= owner_q == PORT_I;
            d_ack_q  <= owner_q == PORT_D;
            if (!mem_we_q && owner_q == PORT_D) d_rdata_q <= bus.mem_rdata;
            if (!mem_we_q && owner_q == PORT_I) i_rdata_q <= bus.mem_rdata;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = state_q != ST_IDLE;
  assign bus.owner_d   = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard queue checked by an ack monitor.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int cyc = 0;
  int en_cnt = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem_arr [64];
  typedef struct {
    logic        d;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus1 ();
  mem_port_arbiter #(.LAT(LAT)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  mem_port_arbiter #(.LAT(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // Memory model: read data is only valid in the LAT-th enabled cycle, garbage otherwise.
  always @(posedge CLK) begin
    en_cnt <= bus.mem_en ? en_cnt + 1 : 0;
    if (cyc == 0) begin
      for (int k = 0; k < 64; k++) mem_arr[k] <= {16'hA5A5, 16'(k)};
      mem_arr[1]  <= 32'h2001_0005;
      mem_arr[2]  <= 32'h2222_2222;
      mem_arr[3]  <= 32'h0C0C_0C0C;
      mem_arr[16] <= 32'h4040_4040;
    end else if (bus.mem_en && bus.mem_we && en_cnt == LAT - 1)
      mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata  = (bus.mem_en && en_cnt == LAT - 1) ? mem_arr[bus.mem_addr[7:2]] : 32'hBAD0_BAD0;
  assign bus1.mem_rdata = bus1.mem_en ? 32'h1234_5678 : 32'hBAD0_BAD0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      chk("ack_overlap", 32'(bus.i_ack & bus.d_ack), 32'd0);
      if (bus.i_ack || bus.d_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ack: got i_ack=%b d_ack=%b at cycle %0d want no ack", bus.i_ack, bus.d_ack, cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_port", 32'(bus.d_ack), 32'(e.d));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("ack_rdata", e.d ? bus.d_rdata : bus.i_rdata, e.rdata);
        end
      end
    end
  endtask
  task automatic access(input logic d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, input logic swap);
    @(posedge CLK);
    #1;
    if (d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = a;
    end
    sb.push_back('{d: d, rdata: exp, cyc: cyc + LAT + 1});
    @(negedge CLK);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < LAT; k++) begin
      @(negedge CLK);
      chk("acc_en", 32'(bus.mem_en), 32'd1);
      chk("acc_we", 32'(bus.mem_we), 32'(d & we));
      chk("acc_addr", bus.mem_addr, a);
      chk("acc_owner", 32'(bus.owner_d), 32'(d));
      if (d && we) chk("acc_wdata", bus.mem_wdata, wd);
      if (swap) begin
        bus.d_addr = 32'h40; bus.d_we = 1'b1; bus.d_wdata = 32'h1111_1111;
      end
    end
    @(negedge CLK);
    chk("done_en", 32'(bus.mem_en), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);
    @(posedge CLK);
    #1;
    if (d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
  endtask
  initial begin
    int c0;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    fork monitor(); join_none
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    chk("rst_i_ack", 32'(bus.i_ack), 32'd0);
    chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_owner", 32'(bus.owner_d), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    // Reset asserted in the middle of a D write must abort it with no ack.
    @(posedge CLK);
    #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'h55AA_55AA;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_en", 32'(bus.mem_en), 32'd1);
    chk("mid_we", 32'(bus.mem_we), 32'd1);
    chk("mid_owner", 32'(bus.owner_d), 32'd1);
    #1 RST = 1'b0;
    #1;
    chk("abort_en", 32'(bus.mem_en), 32'd0);
    chk("abort_we", 32'(bus.mem_we), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_owner", 32'(bus.owner_d), 32'd0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    access(1'b0, 1'b0, 32'h4, 32'h0, 32'h2001_0005, 1'b0);
    access(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access(1'b1, 1'b0, 32'hC, 32'h0, 32'h0C0C_0C0C, 1'b1);
    // Both requesters held after reset: I, D, I, D with four cycles each.
    @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    @(posedge CLK);
    #1;
    c0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h4;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8; bus.d_wdata = '0;
    sb.push_back('{d: 1'b0, rdata: 32'h2001_0005, cyc: c0 + 3});
    sb.push_back('{d: 1'b1, rdata: 32'hDEAD_BEEF, cyc: c0 + 7});
    sb.push_back('{d: 1'b0, rdata: 32'h2001_0005, cyc: c0 + 11});
    sb.push_back('{d: 1'b1, rdata: 32'hDEAD_BEEF, cyc: c0 + 15});
    repeat (16) @(posedge CLK);
    #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sim_idle", 32'(bus.busy), 32'd0);
    // LAT=1 build: one enabled cycle, ack two cycles after the request is seen.
    @(posedge CLK);
    #1;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h20;
    @(negedge CLK);
    chk("l1_idle_en", 32'(bus1.mem_en), 32'd0);
    @(negedge CLK);
    chk("l1_en", 32'(bus1.mem_en), 32'd1);
    chk("l1_addr", bus1.mem_addr, 32'h20);
    chk("l1_no_ack", 32'(bus1.i_ack), 32'd0);
    @(negedge CLK);
    chk("l1_en_off", 32'(bus1.mem_en), 32'd0);
    chk("l1_ack", 32'(bus1.i_ack), 32'd1);
    chk("l1_rdata", bus1.i_rdata, 32'h1234_5678);
    @(posedge CLK);
    #1;
    bus1.i_req = 1'b0;
    @(negedge CLK);
    chk("l1_ack_off", 32'(bus1.i_ack), 32'd0);
    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
